// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial adder controller sharing one external full-adder cell; optional self-check under SERIAL_ADD_CHECK_EN
module serial_add_sequencer #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_ci,
   input  logic             fa_s,
   input  logic             fa_co,
   output logic             chk_err
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    bit_idx_q, bit_idx_d;
   logic [WIDTH-1:0] areg_q, areg_d;
   logic [WIDTH-1:0] breg_q, breg_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             fa_a_q, fa_a_d;
   logic             fa_b_q, fa_b_d;
   logic             fa_ci_q, fa_ci_d;
   logic             last_capture;

   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_DONE);
   assign sum   = sum_q;
   assign cout  = cout_q;
   assign fa_a  = fa_a_q;
   assign fa_b  = fa_b_q;
   assign fa_ci = fa_ci_q;

   assign last_capture = (state_q == ST_CAPTURE) && (bit_idx_q == IW'(WIDTH - 1));

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         areg_q    <= '0;
         breg_q    <= '0;
         acc_q     <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         cout_q    <= 1'b0;
         fa_a_q    <= 1'b0;
         fa_b_q    <= 1'b0;
         fa_ci_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         areg_q    <= areg_d;
         breg_q    <= breg_d;
         acc_q     <= acc_d;
         sum_q     <= sum_d;
         carry_q   <= carry_d;
         cout_q    <= cout_d;
         fa_a_q    <= fa_a_d;
         fa_b_q    <= fa_b_d;
         fa_ci_q   <= fa_ci_d;
      end
   end

   // Next state: cell inputs are loaded on the edge entering SETTLE so they
   // are stable for the whole settle window and the following capture cycle
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      areg_d    = areg_q;
      breg_d    = breg_q;
      acc_d     = acc_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      fa_a_d    = fa_a_q;
      fa_b_d    = fa_b_q;
      fa_ci_d   = fa_ci_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               areg_d    = a;
               breg_d    = b;
               carry_d   = cin;
               bit_idx_d = '0;
               cnt_d     = '0;
               fa_a_d    = a[0];
               fa_b_d    = b[0];
               fa_ci_d   = cin;
               state_d   = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == CW'(SETTLE - 1)) begin
               state_d = ST_CAPTURE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_CAPTURE: begin
            acc_d            = acc_q >> 1;
            acc_d[WIDTH-1]   = fa_s;
            carry_d          = fa_co;
            areg_d           = areg_q >> 1;
            breg_d           = breg_q >> 1;
            cnt_d            = '0;
            if (last_capture) begin
               // Result is published on the same edge that enters DONE
               sum_d   = acc_d;
               cout_d  = fa_co;
               state_d = ST_DONE;
            end else begin
               bit_idx_d = bit_idx_q + IW'(1);
               fa_a_d    = areg_d[0];
               fa_b_d    = breg_d[0];
               fa_ci_d   = fa_co;
               state_d   = ST_SETTLE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef SERIAL_ADD_CHECK_EN
   logic [WIDTH-1:0] a_lat_q, b_lat_q;
   logic             cin_lat_q;
   logic             chk_err_q;
   logic [WIDTH:0]   ref_sum;

   assign ref_sum = {1'b0, a_lat_q} + {1'b0, b_lat_q} + {{WIDTH{1'b0}}, cin_lat_q};
   assign chk_err = chk_err_q;

   // Behavioural cross-check of the serial result; error stays set until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_lat_q   <= '0;
         b_lat_q   <= '0;
         cin_lat_q <= 1'b0;
         chk_err_q <= 1'b0;
      end else begin
         if ((state_q == ST_IDLE) && start) begin
            a_lat_q   <= a;
            b_lat_q   <= b;
            cin_lat_q <= cin;
         end
         if (last_capture && ({carry_d, acc_d} != ref_sum)) begin
            chk_err_q <= 1'b1;
         end
      end
   end
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - self-checking bench with delayed full-adder cell models
module tb_serial_add_sequencer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;

   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout, fa_a, fa_b, fa_ci, fa_s, fa_co, chk_err;
   logic [W-1:0] sum;

   logic         start_f = 1'b0;
   logic [W-1:0] a_f = '0, b_f = '0;
   logic         cin_f = 1'b0;
   logic         busy_f, done_f, cout_f, fa_a_f, fa_b_f, fa_ci_f, fa_s_f, fa_co_f, chk_err_f;
   logic [W-1:0] sum_f;

   int n_cmp = 0;
   int n_fail = 0;

   always #10 clk = ~clk;

   // Gate-level cell: sum path settles in 15, carry path in 55
   assign #15 fa_s    = fa_a ^ fa_b ^ fa_ci;
   assign #55 fa_co   = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);
   assign #15 fa_s_f  = fa_a_f ^ fa_b_f ^ fa_ci_f;
   assign #55 fa_co_f = (fa_a_f & fa_b_f) | (fa_a_f & fa_ci_f) | (fa_b_f & fa_ci_f);

   serial_add_sequencer #(.WIDTH(W), .SETTLE(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout),
      .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci), .fa_s(fa_s), .fa_co(fa_co),
      .chk_err(chk_err)
   );

   serial_add_sequencer #(.WIDTH(W), .SETTLE(1)) u_fast (
      .clk(clk), .rst_n(rst_n), .start(start_f), .a(a_f), .b(b_f), .cin(cin_f),
      .busy(busy_f), .done(done_f), .sum(sum_f), .cout(cout_f),
      .fa_a(fa_a_f), .fa_b(fa_b_f), .fa_ci(fa_ci_f), .fa_s(fa_s_f), .fa_co(fa_co_f),
      .chk_err(chk_err_f)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input string tag);
      logic [W:0]   expv;
      logic [W-1:0] sum_prev;
      logic         cout_prev;
      int           lat;
      bit           busy_ok;
      bit           hold_ok;
      expv      = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
      sum_prev  = sum;
      cout_prev = cout;
      a = av; b = bv; cin = cv; start = 1'b1;
      tick();
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      lat = 0; busy_ok = 1; hold_ok = 1;
      if (busy !== 1'b1) busy_ok = 0;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         tick();
         if (busy !== 1'b1) busy_ok = 0;
         if (done === 1'b1) lat = i;
         else if (sum !== sum_prev || cout !== cout_prev) hold_ok = 0;
      end
      check({tag, "_latency"}, lat, 32);
      check({tag, "_busy"}, 32'(busy_ok), 1);
      check({tag, "_hold"}, 32'(hold_ok), 1);
      check({tag, "_result"}, 32'({cout, sum}), 32'(expv));
      tick();
      check({tag, "_after"}, {30'd0, done, busy}, 0);
   endtask

   initial begin
      int lat;
      int ndone;

      // Reset state
      tick();
      tick();
      check("reset_ctl", {30'd0, busy, done}, 0);
      check("reset_out", {19'd0, cout, fa_a, fa_b, fa_ci, chk_err, sum}, 0);
      check("reset_fast", {22'd0, busy_f, done_f, cout_f, chk_err_f, sum_f}, 0);
      rst_n = 1'b1;
      tick();

      // Directed operands, issued back to back
      run_op(8'h5A, 8'h3C, 1'b0, "op_5a_3c");
      run_op(8'hFF, 8'h01, 1'b0, "op_ff_01");
      run_op(8'hFF, 8'hFF, 1'b1, "op_ff_ff_c");
      run_op(8'h00, 8'h00, 1'b0, "op_zero");

      // Extra start pulses while busy are ignored
      a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0; ndone = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 5 || i == 20) begin
            start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         if (done === 1'b1) begin
            ndone++;
            if (lat == 0) lat = i;
         end
      end
      start = 1'b0;
      check("ign_ndone", ndone, 1);
      check("ign_latency", lat, 32);
      check("ign_result", 32'({cout, sum}), 32'h096);
      check("ign_idle", 32'(busy), 0);

      // Asynchronous reset in the middle of an operation
      run_op(8'hC3, 8'h5F, 1'b1, "pre_rst");
      a = 8'h77; b = 8'h99; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (15) tick();
      #4 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_out", {20'd0, done, cout, fa_a, fa_b, fa_ci, sum}, 0);
      tick();
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) ndone++;
      end
      check("mid_rst_nodone", ndone, 0);
      run_op(8'h77, 8'h99, 1'b1, "post_rst");

      // Random operands against arithmetic reference
      for (int n = 0; n < 16; n++) begin
         run_op(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", n));
      end
      check("main_chk_err", 32'(chk_err), 0);

      // SETTLE=1 cannot wait out the carry path: result must be wrong
      a_f = 8'hFF; b_f = 8'h01; cin_f = 1'b0; start_f = 1'b1;
      tick();
      start_f = 1'b0;
      lat = 0;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         tick();
         if (done_f === 1'b1) lat = i;
      end
      check("fast_latency", lat, 16);
      check("fast_wrong", 32'({cout_f, sum_f} !== 9'h100), 1);
`ifdef SERIAL_ADD_CHECK_EN
      check("fast_chk_set", 32'(chk_err_f), 1);
      repeat (5) tick();
      check("fast_chk_sticky", 32'(chk_err_f), 1);
`else
      check("fast_chk_off", 32'(chk_err_f), 0);
      repeat (5) tick();
      check("fast_chk_off_hold", 32'(chk_err_f), 0);
`endif
      rst_n = 1'b0;
      #1;
      check("fast_chk_rst", 32'(chk_err_f), 0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
